// File: rtl/jk_cmd_sequencer.sv
// Command-driven J/K stimulus generator: buffers hold/reset/set/toggle commands
// in a small FIFO, plays each onto registered j/k for (len+1) clocks, and models downstream q.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CW    = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cmd_valid,
  input  logic [1:0]               cmd_op,
  input  logic [CW-1:0]            cmd_len,
  output logic                     cmd_ready,
  output logic                     j,
  output logic                     k,
  output logic                     q_exp,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 + CW;
  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_DRIVE = 1'b1;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          j_q, j_d, k_q, k_d;
  logic          q_exp_q, q_exp_d;

  logic          push, pop, fifo_nonempty;
  logic [EW-1:0] head;

  assign cmd_ready     = (level_q < LEVEL_FULL);
  assign push          = cmd_valid && cmd_ready;
  assign fifo_nonempty = (level_q != '0);
  assign head          = mem_q[rd_ptr_q];

  // NOTE: every variable gets a default first, so no path through the block infers a latch.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    j_d     = j_q;
    k_d     = k_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        j_d = 1'b0;
        k_d = 1'b0;
        if (fifo_nonempty) begin
          pop        = 1'b1;
          {j_d, k_d} = head[EW-1 -: 2];
          rem_d      = head[CW-1:0];
          state_d    = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (rem_q != '0) begin
          rem_d = rem_q - CW'(1);
        end else if (fifo_nonempty) begin
          // Back-to-back: load the next command with no idle bubble.
          pop        = 1'b1;
          {j_d, k_d} = head[EW-1 -: 2];
          rem_d      = head[CW-1:0];
        end else begin
          j_d     = 1'b0;
          k_d     = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shadow of the downstream JK flip-flop, clocked by the j/k it currently sees.
  always_comb begin
    q_exp_d = q_exp_q;
    case ({j_q, k_q})
      2'b01:   q_exp_d = 1'b0;
      2'b10:   q_exp_d = 1'b1;
      2'b11:   q_exp_d = ~q_exp_q;
      default: q_exp_d = q_exp_q;
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      q_exp_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      j_q     <= j_d;
      k_q     <= k_d;
      q_exp_q <= q_exp_d;
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // NOTE: FIFO storage is not reset; the level and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_len};
  end

  assign j          = j_q;
  assign k          = k_q;
  assign q_exp      = q_exp_q;
  assign fifo_level = level_q;
  assign done       = (state_q == ST_DRIVE) && (rem_q == '0);
  assign busy       = (state_q == ST_DRIVE) || fifo_nonempty;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer: a cycle table of inputs/expected outputs,
// plus hand-written sequences for FIFO-full back-pressure and mid-command reset.
module tb_jk_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_len = 4'd0;
  logic       cmd_ready, j, k, q_exp, busy, done;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;

  jk_cmd_sequencer #(.DEPTH(4), .CW(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_len    (cmd_len),
    .cmd_ready  (cmd_ready),
    .j          (j),
    .k          (k),
    .q_exp      (q_exp),
    .busy       (busy),
    .done       (done),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Observation word: {cmd_ready, fifo_level[2:0], j, k, q_exp, busy, done}
  function automatic logic [8:0] obs();
    return {cmd_ready, fifo_level, j, k, q_exp, busy, done};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive inputs away from the edge, clock once, sample just after the edge.
  task automatic step(input logic v, input logic [1:0] op, input logic [3:0] len);
    @(negedge clk);
    cmd_valid = v;
    cmd_op    = op;
    cmd_len   = len;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rstn;
    logic       valid;
    logic [1:0] op;
    logic [3:0] len;
    logic [8:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic v, input logic [1:0] op,
                     input logic [3:0] len, input logic [8:0] exp);
    vec_t t;
    t.rstn = r; t.valid = v; t.op = op; t.len = len; t.exp = exp;
    vq.push_back(t);
  endtask

  initial begin
    int n;

    // Reset state
    add(0, 0, 2'b00, 4'd0, 9'b1_000_00000);
    // Toggle len=2: three 11 cycles, q 0->1->0->1, done on the third
    add(1, 1, 2'b11, 4'd2, 9'b1_001_00010);
    add(1, 0, 2'b00, 4'd0, 9'b1_000_11010);
    add(1, 0, 2'b00, 4'd0, 9'b1_000_11110);
    add(1, 0, 2'b00, 4'd0, 9'b1_000_11011);
    add(1, 0, 2'b00, 4'd0, 9'b1_000_00100);
    add(1, 0, 2'b00, 4'd0, 9'b1_000_00100);
    // Set len0, reset len1, toggle len0 back-to-back: 10,01,01,11
    add(1, 1, 2'b10, 4'd0, 9'b1_001_00110);
    add(1, 1, 2'b01, 4'd1, 9'b1_001_10111);
    add(1, 1, 2'b11, 4'd0, 9'b1_001_01110);
    add(1, 0, 2'b00, 4'd0, 9'b1_001_01011);
    add(1, 0, 2'b00, 4'd0, 9'b1_000_11011);
    add(1, 0, 2'b00, 4'd0, 9'b1_000_00100);
    // Hold len3 with q=1: four 00 cycles, q stays 1, busy throughout
    add(1, 1, 2'b00, 4'd3, 9'b1_001_00110);
    add(1, 0, 2'b00, 4'd0, 9'b1_000_00110);
    add(1, 0, 2'b00, 4'd0, 9'b1_000_00110);
    add(1, 0, 2'b00, 4'd0, 9'b1_000_00110);
    add(1, 0, 2'b00, 4'd0, 9'b1_000_00111);
    add(1, 0, 2'b00, 4'd0, 9'b1_000_00100);
    // Push and pop on the same edge at level 2; order set, reset, toggle, set
    add(1, 1, 2'b10, 4'd1, 9'b1_001_00110);
    add(1, 1, 2'b01, 4'd0, 9'b1_001_10110);
    add(1, 1, 2'b11, 4'd0, 9'b1_010_10111);
    add(1, 1, 2'b10, 4'd0, 9'b1_010_01111);
    add(1, 0, 2'b00, 4'd0, 9'b1_001_11011);
    add(1, 0, 2'b00, 4'd0, 9'b1_000_10111);
    add(1, 0, 2'b00, 4'd0, 9'b1_000_00100);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rstn      = vq[i].rstn;
      cmd_valid = vq[i].valid;
      cmd_op    = vq[i].op;
      cmd_len   = vq[i].len;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), 32'(obs()), 32'(vq[i].exp));
    end

    // FIFO full back-pressure: one long command driving, four more queued
    step(1, 2'b00, 4'd15);
    step(0, 2'b00, 4'd0);
    check("long_popped", 32'({busy, fifo_level}), 32'({1'b1, 3'd0}));
    for (int i = 0; i < 4; i++) step(1, 2'b00, 4'd15);
    check("full_after_4", 32'({cmd_ready, fifo_level}), 32'({1'b0, 3'd4}));
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 2'b11, 4'd15);
      n++;
      if (cmd_ready) break;
      check($sformatf("held_full%0d", n), 32'(fifo_level), 32'd4);
    end
    check("ready_return_cycles", n, 12);
    check("level_after_pop", 32'(fifo_level), 32'd3);
    step(1, 2'b11, 4'd15);
    check("fifth_accepted", 32'({cmd_ready, fifo_level}), 32'({1'b0, 3'd4}));
    step(0, 2'b00, 4'd0);

    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("flush_reset", 32'(obs()), 32'(9'b1_000_00000));
    @(negedge clk);
    rstn = 1'b1;

    // Mid-command async reset: toggle len7, two queued, reset in drive cycle 3
    step(1, 2'b11, 4'd7);
    step(1, 2'b10, 4'd0);
    step(1, 2'b10, 4'd0);
    step(0, 2'b00, 4'd0);
    check("pre_reset", 32'(obs()), 32'(9'b1_010_11010));
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset", 32'(obs()), 32'(9'b1_000_00000));
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(0, 2'b00, 4'd0);
      check($sformatf("post_reset%0d", i), 32'(obs()), 32'(9'b1_000_00000));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
